// File: rtl/emu_wb_host_if.sv
// Byte-link and Wishbone master signal bundle for emu_wb_host.
// master: the emu_wb_host view; slave: the host link / Wishbone slave side.
interface emu_wb_host_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        wbs_cyc_o;
   logic        wbs_stb_o;
   logic        wbs_we_o;
   logic [3:0]  wbs_sel_o;
   logic [31:0] wbs_adr_o;
   logic [31:0] wbs_dat_o;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_i;
   logic        busy;

   modport master (
      input  rx_data, rx_valid, tx_ready, wbs_dat_i, wbs_ack_i,
      output rx_ready, tx_data, tx_valid, wbs_cyc_o, wbs_stb_o, wbs_we_o,
             wbs_sel_o, wbs_adr_o, wbs_dat_o, busy
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, wbs_dat_i, wbs_ack_i,
      input  rx_ready, tx_data, tx_valid, wbs_cyc_o, wbs_stb_o, wbs_we_o,
             wbs_sel_o, wbs_adr_o, wbs_dat_o, busy
   );
endinterface

// File: rtl/emu_wb_host.sv
// Byte-stream command parser driving single 32-bit Wishbone classic cycles.
// Optional bus timeout enabled by defining EMU_WB_TIMEOUT_EN.
module emu_wb_host #(
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [7:0]  CMD_WRITE      = 8'h57,
   parameter logic [7:0]  CMD_READ       = 8'h52
) (
   input logic            wb_clk_i,
   input logic            wb_rst_i,
   emu_wb_host_if.master  bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_BUS  = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   localparam logic [7:0] ST_OK  = 8'h06;
   localparam logic [7:0] ST_TMO = 8'h15;
   localparam logic [7:0] ST_BAD = 8'h3F;

   logic [2:0]  state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdat_q, wdat_d;
   logic [31:0] rdat_q, rdat_d;
   logic [2:0]  left_q, left_d;
   logic [7:0]  txd_q, txd_d;
   logic        txv_q, txv_d;
   logic        cyc_q, cyc_d;
   logic        wbwe_q, wbwe_d;
   logic [3:0]  sel_q, sel_d;
   logic        rdy_q, rdy_d;
   logic        busy_q, busy_d;
   logic        rx_fire_s, tx_fire_s, tmo_s;

   assign rx_fire_s = bus.rx_valid & rdy_q;
   assign tx_fire_s = txv_q & bus.tx_ready;

`ifdef EMU_WB_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmo_q, tmo_d;

   // tmo_q holds (cycles spent in BUS - 1); zero everywhere else so entry starts clean
   assign tmo_s = (tmo_q == TMO_LAST);

   // Bus-cycle timeout counter next state
   always_comb begin
      tmo_d = '0;
      if (state_q == S_BUS && !tmo_s) begin
         tmo_d = tmo_q + TW'(1);
      end else begin
         tmo_d = '0;
      end
   end

   // Bus-cycle timeout counter register
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   logic unused_tmo_s;
   assign unused_tmo_s = ^TIMEOUT_CYCLES;
   assign tmo_s = 1'b0;
`endif

   // Command parser, bus sequencing and response sequencing
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      left_d  = left_q;
      txd_d   = txd_q;
      case (state_q)
         S_IDLE: begin
            if (rx_fire_s) begin
               if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) begin
                  we_d    = (bus.rx_data == CMD_WRITE);
                  cnt_d   = 2'd0;
                  state_d = S_ADDR;
               end else begin
                  txd_d   = ST_BAD;
                  left_d  = 3'd0;
                  state_d = S_RESP;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ADDR: begin
            if (rx_fire_s) begin
               adr_d = {adr_q[23:0], bus.rx_data};
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = we_q ? S_DATA : S_BUS;
               end else begin
                  state_d = S_ADDR;
               end
            end else begin
               state_d = S_ADDR;
            end
         end
         S_DATA: begin
            if (rx_fire_s) begin
               wdat_d = {wdat_q[23:0], bus.rx_data};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = S_BUS;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               state_d = S_DATA;
            end
         end
         S_BUS: begin
            // Ack is tested first so an ack on the expiry cycle still succeeds
            if (bus.wbs_ack_i) begin
               if (!we_q) begin
                  rdat_d = bus.wbs_dat_i;
                  left_d = 3'd4;
               end else begin
                  left_d = 3'd0;
               end
               txd_d   = ST_OK;
               state_d = S_RESP;
            end else if (tmo_s) begin
               txd_d   = ST_TMO;
               left_d  = 3'd0;
               state_d = S_RESP;
            end else begin
               state_d = S_BUS;
            end
         end
         S_RESP: begin
            if (tx_fire_s) begin
               if (left_q == 3'd0) begin
                  state_d = S_IDLE;
               end else begin
                  txd_d   = rdat_q[31:24];
                  rdat_d  = {rdat_q[23:0], 8'h00};
                  left_d  = left_q - 3'd1;
                  state_d = S_RESP;
               end
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      rdy_d  = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
      busy_d = (state_d != S_IDLE);
      cyc_d  = (state_d == S_BUS);
      wbwe_d = cyc_d & we_d;
      sel_d  = cyc_d ? 4'hF : 4'h0;
      txv_d  = (state_d == S_RESP);
   end

   // State and registered outputs
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         cnt_q   <= 2'd0;
         adr_q   <= 32'h0000_0000;
         wdat_q  <= 32'h0000_0000;
         rdat_q  <= 32'h0000_0000;
         left_q  <= 3'd0;
         txd_q   <= 8'h00;
         txv_q   <= 1'b0;
         cyc_q   <= 1'b0;
         wbwe_q  <= 1'b0;
         sel_q   <= 4'h0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         left_q  <= left_d;
         txd_q   <= txd_d;
         txv_q   <= txv_d;
         cyc_q   <= cyc_d;
         wbwe_q  <= wbwe_d;
         sel_q   <= sel_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.rx_ready  = rdy_q;
   assign bus.tx_data   = txd_q;
   assign bus.tx_valid  = txv_q;
   assign bus.wbs_cyc_o = cyc_q;
   assign bus.wbs_stb_o = cyc_q;
   assign bus.wbs_we_o  = wbwe_q;
   assign bus.wbs_sel_o = sel_q;
   assign bus.wbs_adr_o = adr_q;
   assign bus.wbs_dat_o = wdat_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_emu_wb_host.sv
// Directed bench for emu_wb_host: write, read, bad opcode, stalls, expiry, reset.
module tb_emu_wb_host;
   logic clk = 1'b0;
   logic rst = 1'b1;

   emu_wb_host_if bus_if ();

   emu_wb_host #(
      .TIMEOUT_CYCLES (16),
      .CMD_WRITE      (8'h57),
      .CMD_READ       (8'h52)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // slave model state
   bit          ack_en  = 1'b1;
   int          ack_dly = 0;
   int          cur_len = 0;
   int          last_len = 0;
   int          cyc_total = 0;
   logic [31:0] snap_adr, snap_dat;
   logic        snap_we, snap_stb;
   logic [3:0]  snap_sel;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Wishbone slave: ack after ack_dly wait cycles, snapshot bus on first cycle
   always @(negedge clk) begin
      if (bus_if.wbs_cyc_o) begin
         if (cur_len == 0) begin
            snap_adr = bus_if.wbs_adr_o;
            snap_dat = bus_if.wbs_dat_o;
            snap_we  = bus_if.wbs_we_o;
            snap_stb = bus_if.wbs_stb_o;
            snap_sel = bus_if.wbs_sel_o;
         end
         bus_if.wbs_ack_i = ack_en && (cur_len == ack_dly);
         cur_len++;
         cyc_total++;
      end else begin
         bus_if.wbs_ack_i = 1'b0;
         if (cur_len != 0) last_len = cur_len;
         cur_len = 0;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus_if.rx_data  = b;
      bus_if.rx_valid = 1'b1;
      while (!bus_if.rx_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rx_accept", 32'(bus_if.rx_ready), 32'd1);
      @(negedge clk);
      bus_if.rx_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] op, input logic [31:0] adr,
                           input logic [31:0] dat);
      send_byte(op);
      for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
      if (op == 8'h57) begin
         for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8]);
      end
   endtask

   task automatic get_byte(output logic [7:0] b, output int waited, input bit rnd);
      waited = 0;
      bus_if.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      while (!(bus_if.tx_valid && bus_if.tx_ready) && waited < 300) begin
         @(negedge clk);
         waited++;
         if (rnd) bus_if.tx_ready = 1'($urandom_range(0, 1));
      end
      check("tx_handshake", 32'(bus_if.tx_valid & bus_if.tx_ready), 32'd1);
      b = bus_if.tx_data;
      @(negedge clk);
      bus_if.tx_ready = 1'b0;
   endtask

   task automatic expect_resp(input string tag, input logic [7:0] st, input bit has_data,
                              input logic [31:0] d, input bit rnd);
      logic [7:0] b;
      int w;
      get_byte(b, w, rnd);
      check({tag, "_status"}, 32'(b), 32'(st));
      if (has_data) begin
         for (int i = 3; i >= 0; i--) begin
            get_byte(b, w, rnd);
            check({tag, "_data"}, 32'(b), 32'(d[i*8 +: 8]));
            if (!rnd) check({tag, "_b2b"}, 32'(w), 32'd0);
         end
      end
      check({tag, "_txv_end"}, 32'(bus_if.tx_valid), 32'd0);
      check({tag, "_busy_end"}, 32'(bus_if.busy), 32'd0);
   endtask

   initial begin
      int c0;
      bus_if.rx_data   = 8'h00;
      bus_if.rx_valid  = 1'b0;
      bus_if.tx_ready  = 1'b0;
      bus_if.wbs_dat_i = 32'h0000_0000;
      bus_if.wbs_ack_i = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_outs", {bus_if.rx_ready, bus_if.tx_valid, bus_if.wbs_cyc_o, bus_if.wbs_stb_o,
                         bus_if.wbs_we_o, bus_if.busy, bus_if.wbs_sel_o, bus_if.tx_data}, 32'd0);
      check("rst_adr", bus_if.wbs_adr_o, 32'd0);
      check("rst_dat", bus_if.wbs_dat_o, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_rdy", 32'(bus_if.rx_ready), 32'd1);

      // write, ack after 2 wait cycles
      ack_dly = 2;
      send_cmd(8'h57, 32'h3000_0004, 32'hDEAD_BEEF);
      check("wr_cyc_n1", 32'(bus_if.wbs_cyc_o), 32'd1);
      check("wr_rdy_bus", 32'(bus_if.rx_ready), 32'd0);
      expect_resp("wr", 8'h06, 1'b0, 32'd0, 1'b0);
      check("wr_adr", snap_adr, 32'h3000_0004);
      check("wr_dat", snap_dat, 32'hDEAD_BEEF);
      check("wr_ctl", {snap_we, snap_stb, snap_sel}, 32'h3F);
      check("wr_len", 32'(last_len), 32'd3);
      check("wr_adr_hold", bus_if.wbs_adr_o, 32'h3000_0004);
      check("wr_idle_ctl", {bus_if.wbs_cyc_o, bus_if.wbs_we_o, bus_if.wbs_sel_o}, 32'd0);

      // read, zero-wait ack, random tx_ready
      ack_dly = 0;
      bus_if.wbs_dat_i = 32'h1234_5678;
      send_cmd(8'h52, 32'h3000_0008, 32'd0);
      check("rd_cyc_n1", 32'(bus_if.wbs_cyc_o), 32'd1);
      expect_resp("rd", 8'h06, 1'b1, 32'h1234_5678, 1'b1);
      check("rd_adr", snap_adr, 32'h3000_0008);
      check("rd_ctl", {snap_we, snap_stb, snap_sel}, 32'h1F);
      check("rd_len", 32'(last_len), 32'd1);

      // read with tx_ready held high: one byte per cycle
      bus_if.wbs_dat_i = 32'hA5C3_0F96;
      send_cmd(8'h52, 32'h0000_0010, 32'd0);
      expect_resp("rd2", 8'h06, 1'b1, 32'hA5C3_0F96, 1'b0);

      // unknown opcode
      c0 = cyc_total;
      send_byte(8'hAA);
      expect_resp("bad", 8'h3F, 1'b0, 32'd0, 1'b0);
      check("bad_nocyc", 32'(cyc_total - c0), 32'd0);
      check("bad_rdy", 32'(bus_if.rx_ready), 32'd1);

      // rx_valid during BUS is not consumed
      ack_dly = 5;
      send_cmd(8'h57, 32'h0000_0020, 32'h0102_0304);
      bus_if.rx_data  = 8'h52;
      bus_if.rx_valid = 1'b1;
      repeat (3) begin
         check("bus_rdy_low", 32'(bus_if.rx_ready), 32'd0);
         @(negedge clk);
      end
      bus_if.rx_valid = 1'b0;
      expect_resp("ign", 8'h06, 1'b0, 32'd0, 1'b0);
      check("ign_len", 32'(last_len), 32'd6);

      // ack on the 16th bus cycle (timeout expiry cycle when enabled)
      ack_dly = 15;
      bus_if.wbs_dat_i = 32'hCAFE_F00D;
      send_cmd(8'h52, 32'h0000_0030, 32'd0);
      expect_resp("exp", 8'h06, 1'b1, 32'hCAFE_F00D, 1'b0);
      check("exp_len", 32'(last_len), 32'd16);

`ifdef EMU_WB_TIMEOUT_EN
      ack_en = 1'b0;
      send_cmd(8'h52, 32'h0000_0040, 32'd0);
      expect_resp("tmo", 8'h15, 1'b0, 32'd0, 1'b0);
      check("tmo_len", 32'(last_len), 32'd16);
      ack_en = 1'b1;
`else
      ack_dly = 40;
      bus_if.wbs_dat_i = 32'h0BAD_CAFE;
      send_cmd(8'h52, 32'h0000_0040, 32'd0);
      expect_resp("slow", 8'h06, 1'b1, 32'h0BAD_CAFE, 1'b0);
      check("slow_len", 32'(last_len), 32'd41);
`endif

      // reset after 2 address bytes
      ack_dly = 0;
      send_byte(8'h57);
      send_byte(8'h30);
      send_byte(8'h00);
      rst = 1'b1;
      #1;
      check("rst_cmd_outs", {bus_if.rx_ready, bus_if.busy, bus_if.tx_valid, bus_if.wbs_cyc_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // reset while cyc is high
      ack_en = 1'b0;
      send_cmd(8'h52, 32'h0000_0050, 32'd0);
      check("rst_bus_cyc", 32'(bus_if.wbs_cyc_o), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_bus_outs", {bus_if.wbs_cyc_o, bus_if.wbs_stb_o, bus_if.wbs_we_o, bus_if.wbs_sel_o,
                             bus_if.busy, bus_if.rx_ready, bus_if.tx_valid}, 32'd0);
      check("rst_bus_adr", bus_if.wbs_adr_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ack_en = 1'b1;

      // full write after reset
      ack_dly = 1;
      send_cmd(8'h57, 32'h0000_0040, 32'h1122_3344);
      expect_resp("post", 8'h06, 1'b0, 32'd0, 1'b0);
      check("post_adr", snap_adr, 32'h0000_0040);
      check("post_dat", snap_dat, 32'h1122_3344);
      check("post_len", 32'(last_len), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
